axi_lite_port_arbiter: RTL and testbench

Parametrised N-port memory request arbiter and AXI4-Lite master, the next generation of the core's two-port (fetch/mem) memory front end. It accepts read/write requests from `NUM_PORTS` requesters, grants one at a time round-robin, performs the AXI4-Lite transaction, and returns data plus an error flag to the granted port. Write address and write data are issued concurrently with independent handshakes. Bus errors are reported to the requester.

---
 rtl/axi_lite_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_port_arbiter.sv
// N-port round-robin request arbiter driving a single AXI4-Lite master.
// One transaction in flight; the response pulses back to the owning port.
module axi_lite_port_arbiter #(
    parameter  int NUM_PORTS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_mode,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*STRB_W-1:0]   req_wstrb,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_err,
    output logic [ADDR_W-1:0]             axi_araddr,
    output logic [2:0]                    axi_arprot,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    input  logic [DATA_W-1:0]             axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic                          axi_rvalid,
    output logic                          axi_rready,
    output logic [ADDR_W-1:0]             axi_awaddr,
    output logic [2:0]                    axi_awprot,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [DATA_W-1:0]             axi_wdata,
    output logic [STRB_W-1:0]             axi_wstrb,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t                           state;
    logic [IDX_W-1:0]                 last_grant, owner, grant_idx;
    logic [IDX_W:0]                   scan;
    logic                             grant_any, aw_done, w_done, aw_hs, w_hs;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] port_wdata;
    logic [NUM_PORTS-1:0][STRB_W-1:0] port_wstrb;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign port_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign port_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
        assign port_wstrb[i] = req_wstrb[i*STRB_W +: STRB_W];
    end

    // Scan ports last_grant+1 .. last_grant+NUM_PORTS (mod NUM_PORTS), first valid wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = '0;
        if (state == IDLE) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                scan = {1'b0, last_grant} + (IDX_W+1)'(k);
                if (scan >= (IDX_W+1)'(NUM_PORTS))
                    scan = scan - (IDX_W+1)'(NUM_PORTS);
                if (!grant_any && req_valid[scan[IDX_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = scan[IDX_W-1:0];
                end
            end
        end
        if (grant_any)
            req_ready[grant_idx] = 1'b1;
    end

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid & axi_wready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            last_grant  <= IDX_W'(NUM_PORTS-1);
            owner       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi_araddr  <= '0;
            axi_arprot  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= '0;
            axi_awprot  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: if (grant_any) begin
                    owner      <= grant_idx;
                    last_grant <= grant_idx;
                    if (req_mode[grant_idx]) begin
                        axi_awaddr  <= port_addr[grant_idx];
                        axi_awprot  <= 3'b000;
                        axi_wdata   <= port_wdata[grant_idx];
                        axi_wstrb   <= port_wstrb[grant_idx];
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        state       <= WR_REQ;
                    end else begin
                        axi_araddr  <= port_addr[grant_idx];
                        axi_arprot  <= 3'b000;
                        axi_arvalid <= 1'b1;
                        state       <= RD_ADDR;
                    end
                end
                RD_ADDR: if (axi_arready) begin
                    axi_arvalid <= 1'b0;
                    axi_rready  <= 1'b1;
                    state       <= RD_DATA;
                end
                RD_DATA: if (axi_rvalid) begin
                    axi_rready        <= 1'b0;
                    resp_data         <= axi_rdata;
                    resp_err          <= |axi_rresp;
                    resp_valid[owner] <= 1'b1;
                    state             <= IDLE;
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    // Count this cycle's handshakes so bready rises on the completing edge.
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        axi_bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: if (axi_bvalid) begin
                    axi_bready        <= 1'b0;
                    resp_data         <= '0;
                    resp_err          <= |axi_bresp;
                    resp_valid[owner] <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_port_arbiter.sv
// Bench for axi_lite_port_arbiter: behavioural AXI slave, transaction-level
// scoreboard, and one task per scenario.
module tb_axi_lite_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0, rstn = 1'b0;
    logic [N-1:0]    req_valid = '0, req_mode = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_wstrb = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic [AW-1:0]   axi_araddr, axi_awaddr;
    logic [2:0]      axi_arprot, axi_awprot;
    logic            axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
    logic [DW-1:0]   axi_wdata;
    logic [SW-1:0]   axi_wstrb;
    logic            axi_arready = 0, axi_rvalid = 0, axi_awready = 0, axi_wready = 0, axi_bvalid = 0;
    logic [DW-1:0]   axi_rdata = '0;
    logic [1:0]      axi_rresp = '0, axi_bresp = '0;

    axi_lite_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    // Slave knobs: wait cycles before ready/valid (-1 = random 0..3), response codes (-1 = random).
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, rresp_k = 0, bresp_k = 0;
    bit rd_fixed_en = 0;
    logic [DW-1:0] rd_fixed = '0;

    // Scoreboard state: what the bus outputs must look like in the next sampled cycle.
    bit            busy = 0, m_arv = 0, m_rr = 0, m_awv = 0, m_wv = 0, m_br = 0, aw_got = 0, w_got = 0;
    int            last_g = N - 1, cur_p = 0;
    bit            cur_mode = 0;
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_d = '0, exp_rd = '0, act_rd = '0;
    logic [SW-1:0] cur_s = '0;
    logic [N-1:0]  exp_rv = '0, act_rv = '0;
    logic          exp_re = 0, act_re = 0;
    int            acc_cnt[N];
    int            acc_cyc = 0, aw_cyc = 0, w_cyc = 0, resp_cyc = 0, resp_cnt = 0, br_hi_cnt = 0;
    int            g_q[$];

    function automatic int dly(input int k);
        return (k < 0) ? int'($urandom_range(0, 3)) : k;
    endfunction

    task automatic slave();
        int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
        forever begin
            @(negedge clk);
            if (axi_arvalid) begin axi_arready = (ar_w == 0); if (ar_w > 0) ar_w--; end
            else begin axi_arready = 0; ar_w = dly(ar_dly); end
            if (axi_rready) begin
                axi_rvalid = (r_w == 0);
                if (r_w > 0) r_w--;
                else begin
                    axi_rdata = rd_fixed_en ? rd_fixed : $urandom;
                    axi_rresp = (rresp_k < 0) ? 2'($urandom_range(0, 3)) : 2'(rresp_k);
                end
            end else begin axi_rvalid = 0; r_w = dly(r_dly); end
            if (axi_awvalid) begin axi_awready = (aw_w == 0); if (aw_w > 0) aw_w--; end
            else begin axi_awready = 0; aw_w = dly(aw_dly); end
            if (axi_wvalid) begin axi_wready = (w_w == 0); if (w_w > 0) w_w--; end
            else begin axi_wready = 0; w_w = dly(w_dly); end
            if (aw_got && w_got) begin
                axi_bvalid = (b_w == 0);
                if (b_w > 0) b_w--;
                else axi_bresp = (bresp_k < 0) ? 2'($urandom_range(0, 3)) : 2'(bresp_k);
            end else begin axi_bvalid = 0; b_w = dly(b_dly); end
        end
    endtask

    // Samples 1ns before each rising edge: checks outputs, then applies this edge's handshakes.
    task automatic monitor();
        int g;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk); #4;
            if (!rstn) begin
                busy = 0; last_g = N - 1; exp_rv = '0;
                m_arv = 0; m_rr = 0; m_awv = 0; m_wv = 0; m_br = 0; aw_got = 0; w_got = 0;
                continue;
            end
            g = -1; exp_rdy = '0;
            if (!busy)
                for (int k = 1; k <= N; k++) begin
                    int p = (last_g + k) % N;
                    if (g < 0 && req_valid[p]) g = p;
                end
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL req_ready @%0t got %b exp %b", $time, req_ready, exp_rdy); end
            checks++;
            if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== {m_arv, m_rr, m_awv, m_wv, m_br}) begin
                errors++;
                $display("FAIL bus_ctrl @%0t got arv/rr/awv/wv/br=%b exp %b", $time,
                         {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, {m_arv, m_rr, m_awv, m_wv, m_br});
            end
            if (m_arv) begin
                checks++;
                if ({axi_araddr, axi_arprot} !== {cur_a, 3'b000}) begin errors++; $display("FAIL araddr got %h/%0d exp %h/0", axi_araddr, axi_arprot, cur_a); end
            end
            if (m_awv) begin
                checks++;
                if ({axi_awaddr, axi_awprot} !== {cur_a, 3'b000}) begin errors++; $display("FAIL awaddr got %h/%0d exp %h/0", axi_awaddr, axi_awprot, cur_a); end
            end
            if (m_wv) begin
                checks++;
                if ({axi_wdata, axi_wstrb} !== {cur_d, cur_s}) begin errors++; $display("FAIL wdata got %h/%h exp %h/%h", axi_wdata, axi_wstrb, cur_d, cur_s); end
            end
            checks++;
            if (resp_valid !== exp_rv) begin errors++; $display("FAIL resp_valid @%0t got %b exp %b", $time, resp_valid, exp_rv); end
            if (exp_rv != 0) begin
                checks++;
                if ({resp_data, resp_err} !== {exp_rd, exp_re}) begin errors++; $display("FAIL resp_payload got %h/%b exp %h/%b", resp_data, resp_err, exp_rd, exp_re); end
            end
            if (resp_valid != 0) begin act_rv = resp_valid; act_rd = resp_data; act_re = resp_err; resp_cyc = cyc; resp_cnt++; end
            if (axi_bready) br_hi_cnt++;
            exp_rv = '0;
            if (m_arv && axi_arready) begin m_arv = 0; m_rr = 1; end
            else if (m_rr && axi_rvalid) begin
                m_rr = 0; busy = 0; exp_rv[cur_p] = 1'b1; exp_rd = axi_rdata; exp_re = |axi_rresp;
            end
            if (m_br && axi_bvalid) begin
                m_br = 0; busy = 0; aw_got = 0; w_got = 0; exp_rv[cur_p] = 1'b1; exp_rd = '0; exp_re = |axi_bresp;
            end
            if (m_awv && axi_awready) begin m_awv = 0; aw_got = 1; aw_cyc = cyc; end
            if (m_wv && axi_wready) begin m_wv = 0; w_got = 1; w_cyc = cyc; end
            if (busy && cur_mode && aw_got && w_got) m_br = 1;
            if (g >= 0) begin
                busy = 1; cur_p = g; last_g = g; acc_cnt[g]++; acc_cyc = cyc; g_q.push_back(g);
                cur_mode = req_mode[g]; cur_a = req_addr[g*AW +: AW]; cur_d = req_wdata[g*DW +: DW]; cur_s = req_wstrb[g*SW +: SW];
                if (cur_mode) begin m_awv = 1; m_wv = 1; aw_got = 0; w_got = 0; end
                else m_arv = 1;
            end
        end
    endtask

    task automatic set_knobs(input int ar, input int r, input int aw, input int w, input int b, input int rr, input int br);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; rresp_k = rr; bresp_k = br;
    endtask

    task automatic set_req(input int p, input bit mode, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[p] = 1'b1; req_mode[p] = mode;
        req_addr[p*AW +: AW] = a; req_wdata[p*DW +: DW] = d; req_wstrb[p*SW +: SW] = s;
    endtask

    // Issue one request, drop it after acceptance, wait for its response.
    task automatic do_txn(input int p, input bit mode, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n0, r0, t;
        @(negedge clk);
        n0 = acc_cnt[p]; r0 = resp_cnt;
        set_req(p, mode, a, d, s);
        t = 0;
        while (acc_cnt[p] == n0 && t < 50) begin @(negedge clk); t++; end
        req_valid[p] = 1'b0;
        t = 0;
        while (resp_cnt == r0 && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (resp_cnt == r0) begin errors++; $display("FAIL txn_timeout port %0d addr %h: no response seen", p, a); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #3;
        checks++;
        if ({req_ready, resp_valid, resp_err, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== '0) begin
            errors++; $display("FAIL reset_ctrl got rr=%b rv=%b re=%b bus=%b exp all 0", req_ready, resp_valid, resp_err,
                               {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready});
        end
        checks++;
        if ({axi_araddr, axi_awaddr, axi_wdata, axi_wstrb, axi_arprot, axi_awprot, resp_data} !== '0) begin
            errors++; $display("FAIL reset_payload got ar=%h aw=%h wd=%h ws=%h rd=%h exp 0", axi_araddr, axi_awaddr, axi_wdata, axi_wstrb, resp_data);
        end
        @(negedge clk); req_valid = 3'b111; #2;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant got %b exp 001", req_ready); end
        #1 req_valid = '0;
        @(negedge clk); req_valid = 3'b110; #2;
        checks++;
        if (req_ready !== 3'b010) begin errors++; $display("FAIL grant_skip got %b exp 010", req_ready); end
        #1 req_valid = '0;
    endtask

    task automatic test_round_robin();
        int rem[N], seen[N], base, t;
        set_knobs(-1, -1, -1, -1, -1, -1, -1);
        rd_fixed_en = 0;
        base = g_q.size();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            seen[i] = acc_cnt[i];
            set_req(i, 1'($urandom_range(0, 1)), $urandom & ~32'h3, $urandom, 4'($urandom_range(0, 15)));
            rem[i] = 2;
        end
        t = 0;
        while (t < 3000) begin
            @(negedge clk); t++;
            for (int i = 0; i < N; i++)
                if (acc_cnt[i] != seen[i]) begin
                    seen[i] = acc_cnt[i];
                    if (rem[i] > 0) begin
                        set_req(i, 1'($urandom_range(0, 1)), $urandom & ~32'h3, $urandom, 4'($urandom_range(0, 15)));
                        rem[i]--;
                    end else req_valid[i] = 1'b0;
                end
            if (req_valid == 0 && !busy && exp_rv == 0) break;
        end
        checks++;
        if (g_q.size() - base != 3*N) begin errors++; $display("FAIL rr_count got %0d grants exp %0d", g_q.size() - base, 3*N); end
        for (int k = 0; k < 3*N && base + k < g_q.size(); k++) begin
            checks++;
            if (g_q[base+k] != k % N) begin errors++; $display("FAIL rr_order grant %0d got port %0d exp %0d", k, g_q[base+k], k % N); end
        end
    endtask

    task automatic test_single_read();
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        rd_fixed_en = 1; rd_fixed = 32'hDEADBEEF;
        do_txn(0, 1'b0, 32'h100, '0, '0);
        checks++;
        if ({act_rv, act_rd, act_re} !== {3'b001, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL single_read got %b/%h/%b exp 001/deadbeef/0", act_rv, act_rd, act_re);
        end
        checks++;
        if (resp_cyc - acc_cyc != 3) begin errors++; $display("FAIL read_latency got %0d exp 3", resp_cyc - acc_cyc); end
        rd_fixed_en = 0;
    endtask

    task automatic test_write_split();
        int b0;
        set_knobs(0, 0, 3, 0, 0, 0, 0);
        b0 = br_hi_cnt;
        do_txn(1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
        checks++;
        if (aw_cyc - w_cyc != 3) begin errors++; $display("FAIL w_before_aw got gap %0d exp 3", aw_cyc - w_cyc); end
        checks++;
        if ({act_rv, act_rd, act_re} !== {3'b010, 32'h0, 1'b0}) begin
            errors++; $display("FAIL write_resp got %b/%h/%b exp 010/0/0", act_rv, act_rd, act_re);
        end
        checks++;
        if (resp_cyc - acc_cyc != 6 || br_hi_cnt - b0 != 1) begin
            errors++; $display("FAIL write_split_timing got lat %0d bready %0d exp 6 1", resp_cyc - acc_cyc, br_hi_cnt - b0);
        end
    endtask

    task automatic test_errors();
        set_knobs(0, 0, 0, 0, 0, 2, 0);
        do_txn(2, 1'b0, 32'h400, '0, '0);
        checks++;
        if ({act_rv, act_re} !== {3'b100, 1'b1}) begin errors++; $display("FAIL rresp_err got %b/%b exp 100/1", act_rv, act_re); end
        do_txn(0, 1'b1, 32'h404, 32'hCAFE0001, 4'hF);
        checks++;
        if ({act_rv, act_rd, act_re} !== {3'b001, 32'h0, 1'b0}) begin errors++; $display("FAIL bresp_ok got %b/%h/%b exp 001/0/0", act_rv, act_rd, act_re); end
        set_knobs(0, 0, 0, 0, 0, 0, 3);
        do_txn(1, 1'b1, 32'h408, 32'hCAFE0002, 4'h1);
        checks++;
        if ({act_rv, act_re} !== {3'b010, 1'b1}) begin errors++; $display("FAIL bresp_err got %b/%b exp 010/1", act_rv, act_re); end
    endtask

    task automatic test_reset_mid();
        int n0, rc, t;
        set_knobs(0, 10, 0, 0, 0, 0, 0);
        @(negedge clk);
        n0 = acc_cnt[0];
        set_req(0, 1'b0, 32'h300, '0, '0);
        t = 0;
        while (acc_cnt[0] == n0 && t < 50) begin @(negedge clk); t++; end
        req_valid[0] = 1'b0;
        t = 0;
        while (!axi_rready && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (axi_rready !== 1'b1) begin errors++; $display("FAIL reach_rd_data got rready %b exp 1", axi_rready); end
        rc = resp_cnt;
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1; #3;
        checks++;
        if ({axi_rready, axi_arvalid, resp_valid, axi_araddr} !== '0) begin
            errors++; $display("FAIL mid_reset got rready %b arvalid %b resp %b araddr %h exp 0", axi_rready, axi_arvalid, resp_valid, axi_araddr);
        end
        @(negedge clk); req_valid = 3'b011; #2;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL post_reset_grant got %b exp 001", req_ready); end
        #1 req_valid = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (resp_cnt != rc) begin errors++; $display("FAIL aborted_resp got %0d responses exp 0", resp_cnt - rc); end
    endtask

    task automatic test_same_edge();
        int b0;
        set_knobs(0, 0, 0, 0, 5, 0, 0);
        b0 = br_hi_cnt;
        do_txn(2, 1'b1, 32'h500, 32'hA5A55A5A, 4'b1100);
        checks++;
        if (aw_cyc != w_cyc) begin errors++; $display("FAIL same_edge_hs got aw@%0d w@%0d exp equal", aw_cyc, w_cyc); end
        checks++;
        if (br_hi_cnt - b0 != 6) begin errors++; $display("FAIL bready_hold got %0d cycles exp 6", br_hi_cnt - b0); end
        checks++;
        if (resp_cyc - acc_cyc != 8 || act_rv !== 3'b100 || act_re !== 1'b0) begin
            errors++; $display("FAIL stall_resp got lat %0d rv %b err %b exp 8 100 0", resp_cyc - acc_cyc, act_rv, act_re);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        fork
            monitor();
            slave();
        join_none
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_split();
        test_errors();
        test_reset_mid();
        test_same_edge();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
